// File: rtl/countdown_timer_if.sv
// countdown_timer_if: start/load request and countdown status bundle.
// Ports: Start, counterSeconds, Pause (COUNTDOWN_PAUSE_EN) -> timer;
//        remaining, busy, done -> consumers.
//        master = Start producer side, slave = timer side.

interface countdown_timer_if #(
    parameter int WIDTH = 10
);
    logic             Start;
    logic [WIDTH-1:0] counterSeconds;
`ifdef COUNTDOWN_PAUSE_EN
    logic             Pause;
`endif
    logic [WIDTH-1:0] remaining;
    logic             busy;
    logic             done;

`ifdef COUNTDOWN_PAUSE_EN
    modport master (
        output Start,
        output counterSeconds,
        output Pause,
        input  remaining,
        input  busy,
        input  done
    );

    modport slave (
        input  Start,
        input  counterSeconds,
        input  Pause,
        output remaining,
        output busy,
        output done
    );
`else
    modport master (
        output Start,
        output counterSeconds,
        input  remaining,
        input  busy,
        input  done
    );

    modport slave (
        input  Start,
        input  counterSeconds,
        output remaining,
        output busy,
        output done
    );
`endif
endinterface

// File: rtl/countdown_timer.sv
// countdown_timer: prescaled seconds countdown with one-cycle done pulse.
// Ports: Clock, Reset (async, active-low), bus (countdown_timer_if.slave).
//        Optional freeze input Pause enabled by macro COUNTDOWN_PAUSE_EN.

module countdown_timer #(
    parameter int WIDTH         = 10,
    parameter int TICKS_PER_SEC = 50000000
) (
    input  logic            Clock,
    input  logic            Reset,
    countdown_timer_if.slave bus
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_SEC - 1);

`ifdef COUNTDOWN_PAUSE_EN
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSED
    } state_e;
`else
    typedef enum logic [0:0] {
        IDLE,
        RUN
    } state_e;
`endif

    state_e           state_q;
    logic [PW-1:0]    pre_q;
    logic [PW-1:0]    pre_d;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] rem_d;
    logic             busy_q;
    logic             done_q;

    logic             last_tick_w;
    logic             final_w;

    assign last_tick_w = (pre_q == PRE_LAST);
    // Edge that takes remaining from 1 to 0; wins over a pause request.
    assign final_w     = last_tick_w && (rem_q == WIDTH'(1));

    // Values after one running step of the prescaler.
    always_comb begin
        pre_d = pre_q + PW'(1);
        rem_d = rem_q;
        if (last_tick_w) begin
            pre_d = '0;
            rem_d = rem_q - WIDTH'(1);
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            pre_q   <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.Start) begin
                        rem_q <= bus.counterSeconds;
                        pre_q <= '0;
                        if (bus.counterSeconds == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                        end
                    end
                end
`ifdef COUNTDOWN_PAUSE_EN
                // A pause-free edge advances whether coming from RUN
                // or PAUSED, so the delay equals the paused edges.
                RUN, PAUSED: begin
                    if (final_w) begin
                        state_q <= IDLE;
                        pre_q   <= '0;
                        rem_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (bus.Pause) begin
                        state_q <= PAUSED;
                    end else begin
                        state_q <= RUN;
                        pre_q   <= pre_d;
                        rem_q   <= rem_d;
                    end
                end
`else
                RUN: begin
                    if (final_w) begin
                        state_q <= IDLE;
                        pre_q   <= '0;
                        rem_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        pre_q <= pre_d;
                        rem_q <= rem_d;
                    end
                end
`endif
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.remaining = rem_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: randomized and directed checks of countdown_timer
// against an elapsed-cycle reference model (TICKS_PER_SEC = 2).

module tb_countdown_timer;

    localparam int W = 10;
    localparam int T = 2;

    logic Clock = 1'b0;
    logic Reset = 1'b0;

    countdown_timer_if #(.WIDTH(W)) bus ();

    countdown_timer #(
        .WIDTH        (W),
        .TICKS_PER_SEC(T)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .bus  (bus)
    );

    always #5 Clock = ~Clock;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: a countdown of N lasts N*T running edges.
    bit           m_act;
    bit           m_done;
    int           m_n;
    int           m_el;
    logic [W-1:0] m_rem;
    bit           pz;

    function automatic void model_reset();
        m_act  = 1'b0;
        m_done = 1'b0;
        m_n    = 0;
        m_el   = 0;
        m_rem  = '0;
    endfunction

    function automatic void model_step(input logic st,
                                       input logic [W-1:0] n,
                                       input bit p);
        m_done = 1'b0;
        if (!m_act) begin
            if (st) begin
                m_rem = n;
                if (n == 0) begin
                    m_done = 1'b1;
                end else begin
                    m_act = 1'b1;
                    m_n   = int'(n);
                    m_el  = 0;
                end
            end
        end else if (m_el + 1 == m_n * T) begin
            m_act  = 1'b0;
            m_rem  = '0;
            m_done = 1'b1;
        end else if (!p) begin
            m_el  = m_el + 1;
            m_rem = W'(m_n - m_el / T);
        end
    endfunction

    task automatic drv(input logic st, input logic [W-1:0] n, input bit p);
        bus.Start          = st;
        bus.counterSeconds = n;
        pz                 = p;
`ifdef COUNTDOWN_PAUSE_EN
        bus.Pause = p;
`endif
    endtask

    task automatic tick();
        @(posedge Clock);
        if (Reset) model_step(bus.Start, bus.counterSeconds, pz);
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        drv(1'b0, '0, 1'b0);
        Reset = 1'b0;
        #1;
        for (int j = 0; j < 5; j++) begin
            if (j > 0) tick();
            if (j == 2) Reset = 1'b1;
            n_chk++;
            if ({bus.busy, bus.done, bus.remaining} !== {1'b0, 1'b0, W'(0)}) begin
                n_fail++;
                $display("FAIL reset[%0d]: busy/done/rem got %b/%b/%0d want 0/0/0",
                         j, bus.busy, bus.done, bus.remaining);
            end
        end
    endtask

    task automatic test_basic();
        drv(1'b1, W'(7), 1'b0);
        tick();
        n_chk++;
        if ({bus.busy, bus.remaining} !== {1'b1, W'(7)}) begin
            n_fail++;
            $display("FAIL basic_load: busy/rem got %b/%0d want 1/7",
                     bus.busy, bus.remaining);
        end
        for (int j = 1; j <= 16; j++) begin
            drv(1'b0, W'($urandom_range(1, 1023)), 1'b0);
            tick();
            n_chk++;
            if ({bus.busy, bus.done, bus.remaining} !== {m_act, m_done, m_rem}) begin
                n_fail++;
                $display("FAIL basic[%0d]: busy/done/rem got %b/%b/%0d want %b/%b/%0d",
                         j, bus.busy, bus.done, bus.remaining, m_act, m_done, m_rem);
            end
            if (j == 8) begin
                n_chk++;
                if (bus.remaining !== W'(3)) begin
                    n_fail++;
                    $display("FAIL basic_k8: rem got %0d want 3", bus.remaining);
                end
            end
            if (j == 14) begin
                n_chk++;
                if ({bus.busy, bus.done, bus.remaining} !== {1'b0, 1'b1, W'(0)}) begin
                    n_fail++;
                    $display("FAIL basic_done: busy/done/rem got %b/%b/%0d want 0/1/0",
                             bus.busy, bus.done, bus.remaining);
                end
            end
        end
    endtask

    task automatic test_zero();
        drv(1'b1, W'(0), 1'b0);
        tick();
        n_chk++;
        if ({bus.busy, bus.done, bus.remaining} !== {1'b0, 1'b1, W'(0)}) begin
            n_fail++;
            $display("FAIL zero_pulse: busy/done/rem got %b/%b/%0d want 0/1/0",
                     bus.busy, bus.done, bus.remaining);
        end
        for (int j = 1; j <= 3; j++) begin
            drv(1'b0, W'($urandom_range(1, 1023)), 1'b0);
            tick();
            n_chk++;
            if ({bus.busy, bus.done} !== 2'b00 ||
                {bus.busy, bus.done, bus.remaining} !== {m_act, m_done, m_rem}) begin
                n_fail++;
                $display("FAIL zero[%0d]: busy/done/rem got %b/%b/%0d want %b/%b/%0d",
                         j, bus.busy, bus.done, bus.remaining, m_act, m_done, m_rem);
            end
        end
    endtask

    task automatic test_back_to_back();
        drv(1'b1, W'(7), 1'b0);
        tick();
        for (int j = 1; j <= 28; j++) begin
            if (j == 4)
                drv(1'b1, W'($urandom_range(1, 1023)), 1'b0);
            else if (j >= 12 && j <= 16)
                drv(1'b1, W'(5), 1'b0);
            else
                drv(1'b0, W'($urandom_range(0, 1023)), 1'b0);
            tick();
            n_chk++;
            if ({bus.busy, bus.done, bus.remaining} !== {m_act, m_done, m_rem}) begin
                n_fail++;
                $display("FAIL b2b[%0d]: busy/done/rem got %b/%b/%0d want %b/%b/%0d",
                         j, bus.busy, bus.done, bus.remaining, m_act, m_done, m_rem);
            end
            if (j == 14) begin
                n_chk++;
                if ({bus.busy, bus.done, bus.remaining} !== {1'b0, 1'b1, W'(0)}) begin
                    n_fail++;
                    $display("FAIL b2b_done: busy/done/rem got %b/%b/%0d want 0/1/0",
                             bus.busy, bus.done, bus.remaining);
                end
            end
            if (j == 15) begin
                n_chk++;
                if ({bus.busy, bus.done, bus.remaining} !== {1'b1, 1'b0, W'(5)}) begin
                    n_fail++;
                    $display("FAIL b2b_restart: busy/done/rem got %b/%b/%0d want 1/0/5",
                             bus.busy, bus.done, bus.remaining);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        drv(1'b1, W'(9), 1'b0);
        tick();
        for (int j = 1; j <= 10; j++) begin
            drv(1'b0, '0, 1'b0);
            tick();
        end
        n_chk++;
        if (bus.remaining !== W'(4)) begin
            n_fail++;
            $display("FAIL midrst_pre: rem got %0d want 4", bus.remaining);
        end
        #2;
        Reset = 1'b0;
        model_reset();
        #1;
        n_chk++;
        if ({bus.busy, bus.done, bus.remaining} !== {1'b0, 1'b0, W'(0)}) begin
            n_fail++;
            $display("FAIL midrst_async: busy/done/rem got %b/%b/%0d want 0/0/0",
                     bus.busy, bus.done, bus.remaining);
        end
        tick();
        tick();
        Reset = 1'b1;
        n = $urandom_range(1, 6);
        for (int j = 0; j < n * T + 4; j++) begin
            if (j == 1) drv(1'b1, W'(n), 1'b0);
            else drv(1'b0, W'($urandom_range(0, 1023)), 1'b0);
            tick();
            n_chk++;
            if ({bus.busy, bus.done, bus.remaining} !== {m_act, m_done, m_rem}) begin
                n_fail++;
                $display("FAIL midrst[%0d]: busy/done/rem got %b/%b/%0d want %b/%b/%0d",
                         j, bus.busy, bus.done, bus.remaining, m_act, m_done, m_rem);
            end
        end
    endtask

    task automatic test_random();
        bit p;
        for (int it = 0; it < 8; it++) begin
            drv(1'b1, W'($urandom_range(0, 10)), 1'b0);
            for (int j = 0; j < 30; j++) begin
                tick();
                n_chk++;
                if ({bus.busy, bus.done, bus.remaining} !== {m_act, m_done, m_rem}) begin
                    n_fail++;
                    $display("FAIL rand[%0d.%0d]: busy/done/rem got %b/%b/%0d want %b/%b/%0d",
                             it, j, bus.busy, bus.done, bus.remaining,
                             m_act, m_done, m_rem);
                end
                p = 1'b0;
`ifdef COUNTDOWN_PAUSE_EN
                p = ($urandom_range(0, 3) == 0);
`endif
                drv(($urandom_range(0, 5) == 0), W'($urandom_range(0, 8)), p);
            end
            drv(1'b0, '0, 1'b0);
            for (int j = 0; j < 24; j++) tick();
        end
    endtask

`ifdef COUNTDOWN_PAUSE_EN
    task automatic test_pause();
        drv(1'b1, W'(3), 1'b0);
        tick();
        for (int j = 1; j <= 13; j++) begin
            drv(1'b0, '0, (j >= 2 && j <= 6));
            tick();
            n_chk++;
            if ({bus.busy, bus.done, bus.remaining} !== {m_act, m_done, m_rem}) begin
                n_fail++;
                $display("FAIL pause[%0d]: busy/done/rem got %b/%b/%0d want %b/%b/%0d",
                         j, bus.busy, bus.done, bus.remaining, m_act, m_done, m_rem);
            end
            if (j == 11) begin
                n_chk++;
                if ({bus.busy, bus.done} !== 2'b01) begin
                    n_fail++;
                    $display("FAIL pause_done: busy/done got %b/%b want 0/1",
                             bus.busy, bus.done);
                end
            end
        end
        drv(1'b1, W'(2), 1'b0);
        tick();
        for (int j = 1; j <= 5; j++) begin
            drv(1'b0, '0, (j == 4));
            tick();
            if (j == 4) begin
                n_chk++;
                if ({bus.busy, bus.done, bus.remaining} !== {1'b0, 1'b1, W'(0)}) begin
                    n_fail++;
                    $display("FAIL pause_final: busy/done/rem got %b/%b/%0d want 0/1/0",
                             bus.busy, bus.done, bus.remaining);
                end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_back_to_back();
        test_reset_mid();
`ifdef COUNTDOWN_PAUSE_EN
        test_pause();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
